// File: rtl/and_nand_nor_unit.sv
// Two-operand bitwise AND/NAND/NOR unit with combinational taps and a registered, op-selected result.
// Optional macro AND_NAND_NOR_PARITY_EN adds a registered parity output of the captured result.
module and_nand_nor_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op_sel,
   output logic [WIDTH-1:0] and_c,
   output logic [WIDTH-1:0] nand_c,
   output logic [WIDTH-1:0] nor_c,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_c,
   output logic             op_err
`ifdef AND_NAND_NOR_PARITY_EN
   ,
   output logic             out_par
`endif
);

   logic [WIDTH-1:0] sel_next;
   logic             out_valid_reg;
   logic [WIDTH-1:0] out_c_reg;
   logic             op_err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign and_c[gi]  = a[gi] & b[gi];
         assign nand_c[gi] = ~(a[gi] & b[gi]);
         assign nor_c[gi]  = ~(a[gi] | b[gi]);
      end
   endgenerate

   // Reserved op code selects an all-zero result so out_c never carries stale data with op_err.
   always_comb begin
      sel_next = '0;
      case (op_sel)
         2'b00:   sel_next = and_c;
         2'b01:   sel_next = nand_c;
         2'b10:   sel_next = nor_c;
         default: sel_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_c_reg     <= '0;
         op_err_reg    <= 1'b0;
      end else if (in_valid) begin
         out_valid_reg <= 1'b1;
         out_c_reg     <= sel_next;
         op_err_reg    <= (op_sel == 2'b11);
      end else begin
         out_valid_reg <= 1'b0;
         op_err_reg    <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_c     = out_c_reg;
   assign op_err    = op_err_reg;

`ifdef AND_NAND_NOR_PARITY_EN
   logic out_par_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par_reg <= 1'b0;
      end else if (in_valid) begin
         out_par_reg <= ^sel_next;
      end
   end

   assign out_par = out_par_reg;
`endif

endmodule

// File: tb/tb_and_nand_nor_unit.sv
// Randomized and directed bench for and_nand_nor_unit (WIDTH=8 and WIDTH=1 instances).
module tb_and_nand_nor_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a, b;
   logic [1:0]   op_sel;
   logic [W-1:0] and_c, nand_c, nor_c, out_c;
   logic         out_valid, op_err;
`ifdef AND_NAND_NOR_PARITY_EN
   logic         out_par, out_par1;
`endif

   logic       in_valid1, a1, b1;
   logic [1:0] op_sel1;
   logic       and_c1, nand_c1, nor_c1, out_c1, out_valid1, op_err1;

   int checks = 0;
   int errors = 0;

   // model state for the WIDTH=8 instance
   logic         exp_valid, exp_err, exp_par;
   logic [W-1:0] exp_out;

   always #5 clk = ~clk;

   and_nand_nor_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op_sel(op_sel),
      .and_c(and_c), .nand_c(nand_c), .nor_c(nor_c),
      .out_valid(out_valid), .out_c(out_c), .op_err(op_err)
`ifdef AND_NAND_NOR_PARITY_EN
      , .out_par(out_par)
`endif
   );

   and_nand_nor_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .op_sel(op_sel1),
      .and_c(and_c1), .nand_c(nand_c1), .nor_c(nor_c1),
      .out_valid(out_valid1), .out_c(out_c1), .op_err(op_err1)
`ifdef AND_NAND_NOR_PARITY_EN
      , .out_par(out_par1)
`endif
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Reference: per-bit truth from the count of ones among the two operand bits.
   function automatic logic [63:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                          input int w, input int op);
      logic [63:0] r;
      int s;
      r = '0;
      if (op == 3) return r;
      for (int i = 0; i < w; i++) begin
         s = int'(x[i]) + int'(y[i]);
         case (op)
            0: r[i] = (s == 2);
            1: r[i] = (s != 2);
            default: r[i] = (s == 0);
         endcase
      end
      return r;
   endfunction

   function automatic logic ref_par(input logic [63:0] v, input int w);
      int n;
      n = 0;
      for (int i = 0; i < w; i++) n += int'(v[i]);
      return (n % 2) == 1;
   endfunction

   task automatic comb8(input string tag);
      check_val({tag, "_and"},  and_c,  ref_op(a, b, W, 0));
      check_val({tag, "_nand"}, nand_c, ref_op(a, b, W, 1));
      check_val({tag, "_nor"},  nor_c,  ref_op(a, b, W, 2));
   endtask

   task automatic check_regs8(input string tag);
      check_val({tag, "_valid"}, out_valid, exp_valid);
      check_val({tag, "_out"},   out_c,     exp_out);
      check_val({tag, "_err"},   op_err,    exp_err);
`ifdef AND_NAND_NOR_PARITY_EN
      check_val({tag, "_par"},   out_par,   exp_par);
`endif
   endtask

   // One clock edge on the WIDTH=8 instance with model update from the held inputs.
   task automatic step8(input string tag);
      logic         v;
      logic [W-1:0] sa, sb;
      int           op;
      v = in_valid; sa = a; sb = b; op = int'(op_sel);
      @(posedge clk);
      #1;
      if (v) begin
         exp_valid = 1'b1;
         exp_out   = W'(ref_op(sa, sb, W, op));
         exp_err   = (op == 3);
         exp_par   = ref_par(exp_out, W);
      end else begin
         exp_valid = 1'b0;
         exp_err   = 1'b0;
      end
      check_regs8(tag);
   endtask

   task automatic model_reset();
      exp_valid = 1'b0; exp_out = '0; exp_err = 1'b0; exp_par = 1'b0;
   endtask

   logic [3:0] tbl_and, tbl_nand, tbl_nor;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sel = 2'b00;
      in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; op_sel1 = 2'b00;
      model_reset();
      #12;
      check_regs8("reset");
      check_val("reset_w1_valid", out_valid1, 1'b0);
      check_val("reset_w1_out", out_c1, 1'b0);
      check_val("reset_w1_err", op_err1, 1'b0);
      rst_n = 1'b1;

      // WIDTH=1 truth-table sweep; bit i of each table is the expected value for (a,b)=i
      tbl_and = 4'b1000; tbl_nand = 4'b0111; tbl_nor = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0];
         #1;
         check_val($sformatf("w1_and_%0d", i),  and_c1,  tbl_and[i]);
         check_val($sformatf("w1_nand_%0d", i), nand_c1, tbl_nand[i]);
         check_val($sformatf("w1_nor_%0d", i),  nor_c1,  tbl_nor[i]);
         #9;
      end

      // WIDTH=1 registered NAND
      @(negedge clk);
      in_valid1 = 1'b1; op_sel1 = 2'b01; a1 = 1'b1; b1 = 1'b1;
      @(posedge clk); #1;
      check_val("w1_nand11_valid", out_valid1, 1'b1);
      check_val("w1_nand11_out", out_c1, 1'b0);
      check_val("w1_nand11_err", op_err1, 1'b0);
      a1 = 1'b0;
      @(posedge clk); #1;
      check_val("w1_nand01_out", out_c1, 1'b1);
      in_valid1 = 1'b0;

      // WIDTH=8 back-to-back ops
      in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op_sel = 2'b00;
      #1 comb8("dir");
      step8("dir_and");  check_val("dir_and_const", out_c, 8'h30);
      op_sel = 2'b01;
      step8("dir_nand"); check_val("dir_nand_const", out_c, 8'hCF);
`ifdef AND_NAND_NOR_PARITY_EN
      check_val("dir_nand_par_const", out_par, 1'b0);
`endif
      op_sel = 2'b10;
      step8("dir_nor");  check_val("dir_nor_const", out_c, 8'h03);
`ifdef AND_NAND_NOR_PARITY_EN
      check_val("dir_nor_par_const", out_par, 1'b0);
`endif
      check_val("dir_nor_valid_const", out_valid, 1'b1);
      op_sel = 2'b11;
      step8("dir_rsv");
      check_val("dir_rsv_out_const", out_c, 8'h00);
      check_val("dir_rsv_err_const", op_err, 1'b1);
      in_valid = 1'b0;
      step8("dir_idle");
      check_val("dir_idle_out_const", out_c, 8'h00);
      check_val("dir_idle_err_const", op_err, 1'b0);
`ifdef AND_NAND_NOR_PARITY_EN
      in_valid = 1'b1; a = 8'h01; b = 8'h01; op_sel = 2'b00;
      step8("dir_par");
      check_val("dir_par_const", out_par, 1'b1);
`endif

      // load 0xCF then reset between edges
      in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op_sel = 2'b01;
      step8("pre_rst");
      check_val("pre_rst_const", out_c, 8'hCF);
      op_sel = 2'b00;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs8("mid_rst");
      a = 8'hA5; b = 8'h5A;
      #1 comb8("in_rst");
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         a = W'($urandom); b = W'($urandom);
         op_sel = 2'($urandom_range(0, 3));
         #1 comb8($sformatf("rnd%0d", n));
         step8($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
